// File: rtl/temporal_ngram_encoder.sv
// -----------------------------------------------------------------------------
// temporal_ngram_encoder
//
// Purpose:
//    Producer side of the associative memory query path. Takes a stream of
//    spatial hypervectors and, once a window of NGRAM vectors has been seen,
//    emits one temporal N-gram hypervector per accepted input:
//       hvout = hvin ^ rho(h[0]) ^ rho^2(h[1]) ^ ... ^ rho^(N-1)(h[N-2])
//    where rho is a rotate-left by one bit and h[0] is the newest stored vector.
//    The output side is a single-entry register, so the input can only be
//    taken when that register is empty or is being drained in the same cycle.
//
// Parameters:
//    DIMENSION   hypervector width in bits
//    NGRAM       window length N (>= 1)
//
// Ports:
//    clk         clock, all state updates on the rising edge
//    rst         asynchronous reset, active low
//    seq_clear   synchronous pulse, discards the window at a trial boundary
//    hvin_valid  spatial hypervector valid
//    hvin_ready  encoder can accept hvin this cycle
//    hvin        spatial hypervector
//    dout_valid  N-gram hypervector valid
//    dout_ready  downstream accepts the N-gram hypervector
//    hvout       N-gram hypervector
// -----------------------------------------------------------------------------
module temporal_ngram_encoder #(
   parameter int DIMENSION = 2000,
   parameter int NGRAM     = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 seq_clear,
   input  logic                 hvin_valid,
   output logic                 hvin_ready,
   input  logic [DIMENSION-1:0] hvin,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic [DIMENSION-1:0] hvout
);

   localparam int CNT_W = $clog2(NGRAM + 1);

   // Fill count at which the window is complete; the counter saturates here.
   localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(NGRAM - 1);

   // Fill count after a clear that also accepts a vector: that vector becomes
   // the first entry of the new sequence. With no history there is nothing
   // to fill, so the count stays at zero.
   localparam logic [CNT_W-1:0] FILL_AFTER_CLEAR = (NGRAM > 1) ? CNT_W'(1) : '0;

   logic                 accept;
   logic                 out_handshake;
   logic                 load_out;
   logic [CNT_W-1:0]     fill;
   logic [DIMENSION-1:0] ngram;

   // Rotate left by k positions (modulo the vector width); the top bit wraps
   // into bit 0.
   function automatic logic [DIMENSION-1:0] rotl(input logic [DIMENSION-1:0] x,
                                                 input int                   k);
      int s;
      s = k % DIMENSION;
      if (s == 0) begin
         return x;
      end
      return (x << s) | (x >> (DIMENSION - s));
   endfunction

   // The input is only blocked when a finished result is waiting and the
   // downstream is not taking it this cycle.
   assign hvin_ready    = ~dout_valid | dout_ready;
   assign accept        = hvin_valid & hvin_ready;
   assign out_handshake = dout_valid & dout_ready;

   // A new result is produced when the window is already full at the accept
   // edge. A clear on the same edge starts a fresh sequence instead, except
   // when there is no history at all and every accept is a complete N-gram.
   assign load_out = accept && (fill == FILL_MAX) && (!seq_clear || (NGRAM == 1));

   // Window fill counter: counts accepted vectors up to N-1 and then holds,
   // so the window slides forever without the counter wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill <= '0;
      end else if (seq_clear) begin
         fill <= accept ? FILL_AFTER_CLEAR : '0;
      end else if (accept && (fill != FILL_MAX)) begin
         fill <= fill + CNT_W'(1);
      end
   end

   generate
      if (NGRAM > 1) begin : g_hist
         logic [DIMENSION-1:0] hist [NGRAM-1];

         // History shift register, newest at index 0. A clear zeroes the
         // whole window; an accept on the same edge still lands in slot 0 so
         // that vector starts the new sequence.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int k = 0; k < NGRAM - 1; k++) begin
                  hist[k] <= '0;
               end
            end else if (seq_clear) begin
               for (int k = 1; k < NGRAM - 1; k++) begin
                  hist[k] <= '0;
               end
               hist[0] <= accept ? hvin : '0;
            end else if (accept) begin
               for (int k = 1; k < NGRAM - 1; k++) begin
                  hist[k] <= hist[k-1];
               end
               hist[0] <= hvin;
            end
         end

         // Bind each older vector to its position in time by rotating it
         // once per step of age, then superpose everything with XOR.
         always_comb begin
            ngram = hvin;
            for (int k = 1; k < NGRAM; k++) begin
               ngram = ngram ^ rotl(hist[k-1], k);
            end
         end
      end else begin : g_no_hist
         // With a window of one the N-gram is just the current input.
         assign ngram = hvin;
      end
   endgenerate

   // Single-entry output register. A load wins over a drain on the same
   // edge, which keeps a back-to-back stream free of bubbles; otherwise the
   // valid flag drops once the downstream takes the result. The data itself
   // is left in place after a drain and is only replaced by a new result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_valid <= 1'b0;
         hvout      <= '0;
      end else if (load_out) begin
         dout_valid <= 1'b1;
         hvout      <= ngram;
      end else if (out_handshake) begin
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// -----------------------------------------------------------------------------
// tb_temporal_ngram_encoder
//
// Purpose:
//    Directed bench for temporal_ngram_encoder. Three instances share clock
//    and reset: a narrow NGRAM=3 instance driven with hand-computed vectors,
//    a full-width NGRAM=3 instance driven with random vectors and stalls
//    against a golden model, and a narrow NGRAM=1 instance.
// -----------------------------------------------------------------------------
module tb_temporal_ngram_encoder;

   localparam int WIDE = 2000;
   localparam int RAND_ACCEPTS = 120;
   localparam int RAND_CYCLE_LIMIT = 5000;

   logic clk;
   logic rst;

   // Narrow NGRAM=3 instance
   logic       a_clear, a_valid, a_ready, a_hvin_ready, a_dout_valid;
   logic [7:0] a_hvin, a_hvout;

   // Wide NGRAM=3 instance
   logic            b_clear, b_valid, b_ready, b_hvin_ready, b_dout_valid;
   logic [WIDE-1:0] b_hvin, b_hvout;

   // Narrow NGRAM=1 instance
   logic       c_clear, c_valid, c_ready, c_hvin_ready, c_dout_valid;
   logic [7:0] c_hvin, c_hvout;

   int n_total = 0;
   int n_pass  = 0;

   temporal_ngram_encoder #(.DIMENSION(8), .NGRAM(3)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .seq_clear  (a_clear),
      .hvin_valid (a_valid),
      .hvin_ready (a_hvin_ready),
      .hvin       (a_hvin),
      .dout_valid (a_dout_valid),
      .dout_ready (a_ready),
      .hvout      (a_hvout)
   );

   temporal_ngram_encoder #(.DIMENSION(WIDE), .NGRAM(3)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .seq_clear  (b_clear),
      .hvin_valid (b_valid),
      .hvin_ready (b_hvin_ready),
      .hvin       (b_hvin),
      .dout_valid (b_dout_valid),
      .dout_ready (b_ready),
      .hvout      (b_hvout)
   );

   temporal_ngram_encoder #(.DIMENSION(8), .NGRAM(1)) dut_c (
      .clk        (clk),
      .rst        (rst),
      .seq_clear  (c_clear),
      .hvin_valid (c_valid),
      .hvin_ready (c_hvin_ready),
      .hvin       (c_hvin),
      .dout_valid (c_dout_valid),
      .dout_ready (c_ready),
      .hvout      (c_hvout)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge, where outputs are stable
   // and new inputs can be driven for the following edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   // Wide compare; only the low 64 bits are printed to keep lines short.
   task automatic check_wide(input string tag, input logic [WIDE-1:0] obs, input logic [WIDE-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("[TB] FAIL %s: observed[63:0] %h, expected[63:0] %h", tag, obs[63:0], exp[63:0]);
   endtask

   // Reference rotations written as explicit bit concatenations.
   function automatic logic [WIDE-1:0] rho1(input logic [WIDE-1:0] x);
      return {x[WIDE-2:0], x[WIDE-1]};
   endfunction

   function automatic logic [WIDE-1:0] rho2(input logic [WIDE-1:0] x);
      return {x[WIDE-3:0], x[WIDE-1:WIDE-2]};
   endfunction

   function automatic logic [WIDE-1:0] rand_hv();
      logic [WIDE-1:0] v;
      v = '0;
      for (int i = 0; i < 63; i++) begin
         v = {v[WIDE-33:0], 32'($urandom)};
      end
      return v;
   endfunction

   // Single directed sequence covering every scenario in order.
   initial begin
      logic [WIDE-1:0] m_h0, m_h1, m_out;
      logic            m_dv, m_rdy, m_acc;
      int              m_fill, n_acc, cycles;

      rst = 1'b1;
      a_clear = 1'b0; a_valid = 1'b0; a_ready = 1'b0; a_hvin = '0;
      b_clear = 1'b0; b_valid = 1'b0; b_ready = 1'b0; b_hvin = '0;
      c_clear = 1'b0; c_valid = 1'b0; c_ready = 1'b0; c_hvin = '0;

      // Reset state
      #2 rst = 1'b0;
      #1;
      check_output("reset_dout_valid", 32'(a_dout_valid), 32'h0);
      check_output("reset_hvout", 32'(a_hvout), 32'h0);
      check_output("reset_hvin_ready", 32'(a_hvin_ready), 32'h1);
      tick();
      rst = 1'b1;
      a_ready = 1'b1;

      // Fill phase: no output until the third accept
      a_valid = 1'b1; a_hvin = 8'h01;
      tick();
      check_output("fill1_dout_valid", 32'(a_dout_valid), 32'h0);
      a_hvin = 8'h10;
      tick();
      check_output("fill2_dout_valid", 32'(a_dout_valid), 32'h0);
      a_hvin = 8'h03;
      tick();
      check_output("fill3_dout_valid", 32'(a_dout_valid), 32'h1);
      check_output("fill3_hvout", 32'(a_hvout), 32'h27);

      // Back-pressure: output held, input blocked, ignored input changes
      a_ready = 1'b0; a_hvin = 8'h80;
      #1;
      check_output("bp_hvin_ready", 32'(a_hvin_ready), 32'h0);
      a_hvin = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_output("bp_hold_hvout", 32'(a_hvout), 32'h27);
         check_output("bp_hold_valid", 32'(a_dout_valid), 32'h1);
      end

      // Release: simultaneous drain and accept, window slides with wrap
      a_ready = 1'b1; a_hvin = 8'h80;
      tick();
      check_output("slide1_hvout", 32'(a_hvout), 32'hC6);
      check_output("slide1_valid", 32'(a_dout_valid), 32'h1);
      tick();
      check_output("slide2_hvout", 32'(a_hvout), 32'h8D);
      check_output("slide2_valid", 32'(a_dout_valid), 32'h1);

      // Clear together with accept of 0x05: no output, new sequence begins
      a_clear = 1'b1; a_hvin = 8'h05;
      tick();
      check_output("clear_valid", 32'(a_dout_valid), 32'h0);
      a_clear = 1'b0; a_hvin = 8'h01;
      tick();
      check_output("clear_next1_valid", 32'(a_dout_valid), 32'h0);
      a_hvin = 8'h02;
      tick();
      check_output("clear_next2_valid", 32'(a_dout_valid), 32'h1);
      check_output("clear_next2_hvout", 32'(a_hvout), 32'h14);

      // Clear while a result is pending keeps that result
      a_valid = 1'b0; a_ready = 1'b0; a_clear = 1'b1;
      tick();
      a_clear = 1'b0;
      check_output("clear_pending_valid", 32'(a_dout_valid), 32'h1);
      check_output("clear_pending_hvout", 32'(a_hvout), 32'h14);
      a_ready = 1'b1;
      tick();
      check_output("drain_valid", 32'(a_dout_valid), 32'h0);

      // Window restarted empty: three accepts needed for the next output
      a_valid = 1'b1; a_hvin = 8'h01;
      tick();
      a_hvin = 8'h02;
      tick();
      check_output("refill2_valid", 32'(a_dout_valid), 32'h0);
      a_hvin = 8'h03; a_ready = 1'b0;
      tick();
      a_valid = 1'b0;
      check_output("refill3_hvout", 32'(a_hvout), 32'h03);
      check_output("refill3_valid", 32'(a_dout_valid), 32'h1);

      // Asynchronous reset mid-window with a result pending
      #2 rst = 1'b0;
      #1;
      check_output("async_reset_valid", 32'(a_dout_valid), 32'h0);
      check_output("async_reset_hvout", 32'(a_hvout), 32'h0);
      #2 rst = 1'b1;
      a_ready = 1'b1; a_valid = 1'b1; a_hvin = 8'h11;
      tick();
      check_output("post_reset1_valid", 32'(a_dout_valid), 32'h0);
      a_hvin = 8'h22;
      tick();
      check_output("post_reset2_valid", 32'(a_dout_valid), 32'h0);
      a_hvin = 8'h33;
      tick();
      check_output("post_reset3_valid", 32'(a_dout_valid), 32'h1);
      check_output("post_reset3_hvout", 32'(a_hvout), 32'h33);
      a_valid = 1'b0;
      tick();
      check_output("idle_valid", 32'(a_dout_valid), 32'h0);

      // NGRAM=1: every accept passes straight through, including with clear
      c_ready = 1'b1; c_valid = 1'b1; c_hvin = 8'hA5;
      tick();
      check_output("n1_first_valid", 32'(c_dout_valid), 32'h1);
      check_output("n1_first_hvout", 32'(c_hvout), 32'hA5);
      c_hvin = 8'h3C;
      tick();
      check_output("n1_second_hvout", 32'(c_hvout), 32'h3C);
      c_clear = 1'b1; c_hvin = 8'h5A;
      tick();
      check_output("n1_clear_valid", 32'(c_dout_valid), 32'h1);
      check_output("n1_clear_hvout", 32'(c_hvout), 32'h5A);
      c_clear = 1'b0; c_valid = 1'b0;
      tick();
      check_output("n1_drain_valid", 32'(c_dout_valid), 32'h0);

      // Wide instance: random vectors and stalls against a golden model
      m_h0 = '0; m_h1 = '0; m_out = '0; m_dv = 1'b0;
      m_fill = 0; n_acc = 0; cycles = 0;
      while ((n_acc < RAND_ACCEPTS) && (cycles < RAND_CYCLE_LIMIT)) begin
         b_valid = ($urandom_range(0, 3) != 0);
         b_ready = ($urandom_range(0, 3) != 0);
         b_hvin  = rand_hv();
         #1;
         m_rdy = !m_dv || b_ready;
         check_output("rand_hvin_ready", 32'(b_hvin_ready), 32'(m_rdy));
         m_acc = b_valid && m_rdy;
         if (m_dv && b_ready) begin
            m_dv = 1'b0;
         end
         if (m_acc) begin
            if (m_fill == 2) begin
               m_out = b_hvin ^ rho1(m_h0) ^ rho2(m_h1);
               m_dv  = 1'b1;
            end else begin
               m_fill++;
            end
            m_h1 = m_h0;
            m_h0 = b_hvin;
            n_acc++;
         end
         tick();
         cycles++;
         check_output("rand_dout_valid", 32'(b_dout_valid), 32'(m_dv));
         if (m_dv) begin
            check_wide("rand_hvout", b_hvout, m_out);
         end
      end
      b_valid = 1'b0;
      check_output("rand_accept_count", 32'(n_acc), 32'(RAND_ACCEPTS));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
